md_iterative_unit: RTL

Multi-cycle RV32M multiply/divide execution unit in the EX stage. It consumes the md_type, md_operation and operand fields launched by the ID/EX pipeline register. It drives md_alu_stall back to that register and to the IF/ID stage, holding the pipeline until the result is ready. The result is muxed into the EX result path in the cycle md_done is high.

---
 rtl/md_iterative_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/md_iterative_unit.sv
// RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro FAST_MUL_EN: single-cycle combinational multiply; divide keeps the iterative path.
module md_iterative_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            riscv_start,
  input  logic            riscv_done,
  input  logic            flush,
  input  logic            dcache_stall,
  input  logic            id_ex_md_type,
  input  logic            id_ex_reg_write,
  input  logic [2:0]      id_ex_md_operation,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] md_result,
  output logic            md_done,
  output logic            md_alu_stall,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opd;
  logic [2:0]        op_q;
  logic              sign_a_q, sign_b_q;

  // Launch-side decode of the instruction sitting in ID/EX.
  logic            adv, start, is_div;
  logic            a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_val;
  logic            take_fast;
  logic [XLEN-1:0] fast_result;

  assign adv    = riscv_start && !riscv_done;
  assign start  = id_ex_md_type && id_ex_reg_write && (state == IDLE);
  assign is_div = id_ex_md_operation[2];

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (id_ex_md_operation)
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU:                          a_signed = 1'b1;
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: ;
      default:                            ;
    endcase
  end

  assign sign_a = a_signed && op_a[XLEN-1];
  assign sign_b = b_signed && op_b[XLEN-1];
  assign a_mag  = sign_a ? -op_a : op_a;
  assign b_mag  = sign_b ? -op_b : op_b;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !id_ex_md_operation[0] && (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_val = '0;
    if (div_zero) special_val = id_ex_md_operation[1] ? op_a : '1;
    else          special_val = id_ex_md_operation[1] ? '0 : INT_MIN;
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod   = $signed({{XLEN{sign_a}}, op_a}) * $signed({{XLEN{sign_b}}, op_b});
  assign take_fast   = !is_div;
  assign fast_result = (id_ex_md_operation == OP_MUL) ? fast_prod[XLEN-1:0]
                                                      : fast_prod[2*XLEN-1:XLEN];
`else
  assign take_fast   = 1'b0;
  assign fast_result = '0;
`endif

  // One iteration: acc holds {partial/remainder, multiplier/quotient} and shifts right/left.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opd};
    div_rem   = div_ge ? (div_shift[XLEN-1:0] - opd) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc[XLEN-2:0], div_ge};
    acc_next  = op_q[2] ? div_next : mul_next;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_s, rem_s, iter_result;

  always_comb begin
    prod  = (sign_a_q ^ sign_b_q) ? -acc_next : acc_next;
    quo_s = (sign_a_q ^ sign_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_s = sign_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       iter_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: iter_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              iter_result = quo_s;
      OP_REM, OP_REMU:              iter_result = rem_s;
      default:                      iter_result = rem_s;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (special || take_fast) ? DONE : BUSY;
      BUSY:    if (cnt == LAST_CNT) state_next = DONE;
      DONE:    if (!dcache_stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opd       <= '0;
      op_q      <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      md_result <= '0;
    end else if (adv) begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q     <= id_ex_md_operation;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            cnt      <= '0;
            // Divide shifts the dividend out of the low half; multiply shifts the multiplier.
            if (is_div) begin
              acc <= {{XLEN{1'b0}}, a_mag};
              opd <= b_mag;
            end else begin
              acc <= {{XLEN{1'b0}}, b_mag};
              opd <= a_mag;
            end
            if (special)        md_result <= special_val;
            else if (take_fast) md_result <= fast_result;
          end
        end
        BUSY: begin
          if (!flush) begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) md_result <= iter_result;
          end
        end
        default: ;
      endcase
    end
  end

  // md_alu_stall stays combinational so flush releases the pipeline in the same cycle.
  assign md_alu_stall = id_ex_md_type && id_ex_reg_write && (state != DONE) && !flush;
  assign md_done      = (state == DONE);
  assign dbg_state    = state;

endmodule
